// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer: N-channel push-button front end.
// Each raw button is synchronised, filtered over DEPTH sample ticks and
// reported as a clean level plus one-cycle press/release pulses.
// lastPressed tracks the lowest-indexed channel of the most recent press
// pulse. Define AUTO_REPEAT_EN to add held-button auto-repeat press pulses.
module multi_button_debouncer #(
  parameter int N_CH          = 4,
  parameter int DEPTH         = 3,
  parameter int IDX_W         = 2,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic             fastClk,
  input  logic             rstN,
  input  logic             sampleTick,
  input  logic [N_CH-1:0]  buttonIn,
  output logic [N_CH-1:0]  buttonLevel,
  output logic [N_CH-1:0]  pressPulse,
  output logic [N_CH-1:0]  releasePulse,
  output logic             anyPressed,
  output logic [IDX_W-1:0] lastPressed
);

  // Reject parameter sets outside the supported ranges at elaboration.
  if (N_CH < 1 || N_CH > 16 || DEPTH < 2 || DEPTH > 8 || IDX_W < 1 ||
      (2 ** IDX_W) < N_CH || REPEAT_DELAY < 1 || REPEAT_DELAY > 255 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_bad_cfg
    $error("multi_button_debouncer: illegal parameter set");
  end

  logic [N_CH-1:0]            sync1_q, sync2_q;
  logic [N_CH-1:0][DEPTH-1:0] shift_q, shift_d;
  logic [N_CH-1:0]            level_q, level_d;
  logic [N_CH-1:0]            press_q, press_d;
  logic [N_CH-1:0]            rel_q, rel_d;
  logic [N_CH-1:0]            pulse_d;
  logic [IDX_W-1:0]           last_q, last_d;

  // Sample shifting and level acceptance: a full run of equal samples that
  // disagrees with the current level flips it and raises one pulse.
  always_comb begin
    shift_d = shift_q;
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (sampleTick) begin
        shift_d[c] = {shift_q[c][DEPTH-2:0], sync2_q[c]};
      end
      if ((&shift_q[c]) && !level_q[c]) begin
        press_d[c] = 1'b1;
        level_d[c] = 1'b1;
      end else if (!(|shift_q[c]) && level_q[c]) begin
        rel_d[c]   = 1'b1;
        level_d[c] = 1'b0;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [7:0] DELAY_C  = 8'(REPEAT_DELAY);
  // Reloading to DELAY-PERIOD makes every later repeat land PERIOD ticks apart
  // while only ever comparing against one threshold.
  localparam logic [7:0] RELOAD_C = (REPEAT_PERIOD >= REPEAT_DELAY) ? 8'd0 :
                                    8'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [N_CH-1:0][7:0] hold_q, hold_d;
  logic [N_CH-1:0]      rep_d;

  // Hold counters: count ticks while a level is held, fire a repeat at the
  // threshold; released channels (including the release cycle) stay cleared.
  always_comb begin
    hold_d = hold_q;
    rep_d  = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (!level_q[c] || rel_d[c]) begin
        hold_d[c] = '0;
      end else if (sampleTick && (hold_q[c] != 8'hFF)) begin
        if ((hold_q[c] + 8'd1) == DELAY_C) begin
          rep_d[c]  = 1'b1;
          hold_d[c] = RELOAD_C;
        end else begin
          hold_d[c] = hold_q[c] + 8'd1;
        end
      end
    end
  end

  // Hold counter registers.
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign pulse_d = press_d | rep_d;
`else
  assign pulse_d = press_d;
`endif

  // Last-pressed tracking: scan downward so the lowest pulsing index wins.
  always_comb begin
    last_d = last_q;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (pulse_d[i-1]) last_d = IDX_W'(i - 1);
    end
  end

  // Synchronisers, shifters, levels, pulses and last-pressed registers.
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      shift_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      last_q  <= '0;
    end else begin
      sync1_q <= buttonIn;
      sync2_q <= sync1_q;
      shift_q <= shift_d;
      level_q <= level_d;
      press_q <= pulse_d;
      rel_q   <= rel_d;
      last_q  <= last_d;
    end
  end

  assign buttonLevel  = level_q;
  assign pressPulse   = press_q;
  assign releasePulse = rel_q;
  assign anyPressed   = |level_q;
  assign lastPressed  = last_q;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: directed scenarios plus a random phase,
// every cycle checked against a run-length reference model.
module tb_multi_button_debouncer;
  localparam int N_CH = 4;
  localparam int DEPTH = 3;
  localparam int IDX_W = 2;
  localparam int RD = 8;
  localparam int RP = 4;

  logic fastClk = 1'b0;
  logic rstN = 1'b0;
  logic sampleTick = 1'b0;
  logic [N_CH-1:0] buttonIn = '0;
  logic [N_CH-1:0] buttonLevel, pressPulse, releasePulse;
  logic anyPressed;
  logic [IDX_W-1:0] lastPressed;

  int tests = 0;
  int fails = 0;
  int phase = 0;
  logic last_tick;

  multi_button_debouncer #(
    .N_CH(N_CH), .DEPTH(DEPTH), .IDX_W(IDX_W),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .fastClk(fastClk), .rstN(rstN), .sampleTick(sampleTick),
    .buttonIn(buttonIn), .buttonLevel(buttonLevel), .pressPulse(pressPulse),
    .releasePulse(releasePulse), .anyPressed(anyPressed),
    .lastPressed(lastPressed)
  );

  always #5 fastClk = ~fastClk;

  // Reference model: two-stage delay line, per-channel run of equal samples.
  logic [N_CH-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
  logic [IDX_W-1:0] m_last;
  int m_rv[N_CH];
  int m_rl[N_CH];
  int m_hold[N_CH];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_last = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_rv[c] = 0; m_rl[c] = DEPTH; m_hold[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [N_CH-1:0] np, nr, nl;
    if (!rstN) begin
      model_reset();
      return;
    end
    np = '0; nr = '0; nl = m_lvl;
    for (int c = 0; c < N_CH; c++) begin
      if (m_rl[c] >= DEPTH && m_rv[c] == 1 && !m_lvl[c]) begin
        np[c] = 1'b1; nl[c] = 1'b1;
      end else if (m_rl[c] >= DEPTH && m_rv[c] == 0 && m_lvl[c]) begin
        nr[c] = 1'b1; nl[c] = 1'b0;
      end
`ifdef AUTO_REPEAT_EN
      if (!m_lvl[c] || nr[c]) m_hold[c] = 0;
      else if (sampleTick) begin
        m_hold[c]++;
        if (m_hold[c] >= RD && ((m_hold[c] - RD) % RP) == 0) np[c] = 1'b1;
      end
`endif
    end
    for (int c = N_CH - 1; c >= 0; c--) if (np[c]) m_last = IDX_W'(c);
    if (sampleTick) begin
      for (int c = 0; c < N_CH; c++) begin
        if (int'(m_s2[c]) == m_rv[c]) begin
          if (m_rl[c] < 1000) m_rl[c]++;
        end else begin
          m_rv[c] = int'(m_s2[c]); m_rl[c] = 1;
        end
      end
    end
    m_s2 = m_s1; m_s1 = buttonIn;
    m_lvl = nl; m_prs = np; m_rel = nr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model consumes pre-edge inputs, DUT compared 1 time unit later.
  task automatic cyc();
    logic [14:0] exp_v, obs_v;
    model_step();
    last_tick = sampleTick;
    @(posedge fastClk); #1;
    exp_v = {m_lvl, m_prs, m_rel, |m_lvl, m_last};
    obs_v = {buttonLevel, pressPulse, releasePulse, anyPressed, lastPressed};
    chk("model_cycle", 32'(obs_v), 32'(exp_v));
    phase++;
    sampleTick = ((phase % 4) == 3);
  endtask

  task automatic wait_pulse(input bit rel, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if ((rel ? releasePulse : pressPulse) != '0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit got;
    int np, nr;
    int tq[$];
    model_reset();

    // 1: reset with all buttons high, then release reset.
    buttonIn = 4'hF;
    rstN = 1'b0;
    #1;
    chk("t1_reset_outputs", 32'({buttonLevel, pressPulse, releasePulse, anyPressed, lastPressed}), 32'd0);
    cyc(); cyc();
    chk("t1_reset_hold", 32'({buttonLevel, pressPulse, releasePulse, anyPressed}), 32'd0);
    rstN = 1'b1;
    wait_pulse(1'b0, 40, got);
    chk("t1_press_seen", 32'(got), 32'd1);
    chk("t1_press_all", 32'(pressPulse), 32'hF);
    chk("t1_level_all", 32'(buttonLevel), 32'hF);
    cyc();
    chk("t1_press_one_cycle", 32'(pressPulse), 32'h0);
    buttonIn = 4'h0;
    wait_pulse(1'b1, 40, got);
    chk("t1_release_all", 32'(releasePulse), 32'hF);

    // 2: bounce on channel 1, then stable high.
    np = 0; nr = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < 40 && (i % 5) == 0) buttonIn[1] = ~buttonIn[1];
      if (i == 40) buttonIn[1] = 1'b1;
      cyc();
      if (pressPulse[1]) np++;
      if (releasePulse[1]) nr++;
    end
    chk("t2_press_count", 32'(np), 32'd1);
    chk("t2_release_count", 32'(nr), 32'd0);
    chk("t2_last", 32'(lastPressed), 32'd1);
    buttonIn = 4'h0;
    wait_pulse(1'b1, 40, got);
    chk("t2_release_seen", 32'(got), 32'd1);

    // 3: simultaneous press of channels 1 and 3.
    buttonIn = 4'b1010;
    wait_pulse(1'b0, 40, got);
    chk("t3_press_pattern", 32'(pressPulse), 32'b1010);
    chk("t3_last_lowest", 32'(lastPressed), 32'd1);
    chk("t3_any", 32'(anyPressed), 32'd1);
    cyc();
    chk("t3_press_one_cycle", 32'(pressPulse), 32'h0);

    // 4: release channel 3 only.
    buttonIn = 4'b0010;
    wait_pulse(1'b1, 40, got);
    chk("t4_release_pattern", 32'(releasePulse), 32'b1000);
    chk("t4_level", 32'(buttonLevel), 32'b0010);
    chk("t4_last_held", 32'(lastPressed), 32'd1);
    buttonIn = 4'h0;
    wait_pulse(1'b1, 40, got);
    chk("t4_release_rest", 32'(releasePulse), 32'b0010);

    // 5: reset after two of three press samples on channel 0.
    buttonIn = 4'b0001;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (m_rv[0] == 1 && m_rl[0] == 2) begin got = 1'b1; break; end
    end
    chk("t5_partial_reached", 32'(got), 32'd1);
    rstN = 1'b0;
    np = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      np += int'(pressPulse != '0);
    end
    chk("t5_outputs_in_reset", 32'({buttonLevel, pressPulse, releasePulse, lastPressed}), 32'd0);
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      np += int'(pressPulse != '0);
    end
    chk("t5_no_early_pulse", 32'(np), 32'd0);
    wait_pulse(1'b0, 40, got);
    chk("t5_fresh_press", 32'(pressPulse), 32'b0001);
    buttonIn = 4'h0;
    wait_pulse(1'b1, 40, got);
    chk("t5_release_seen", 32'(got), 32'd1);

    // Random phase: random patterns held for random lengths.
    for (int k = 0; k < 60; k++) begin
      buttonIn = 4'($urandom_range(0, 15));
      for (int h = 0; h < int'($urandom_range(1, 20)); h++) cyc();
    end
    buttonIn = 4'h0;
    for (int i = 0; i < 30; i++) cyc();
    chk("rand_settle_level", 32'(buttonLevel), 32'h0);

`ifdef AUTO_REPEAT_EN
    // 6: hold channel 2, record tick offsets of every press pulse.
    buttonIn = 4'b0100;
    wait_pulse(1'b0, 40, got);
    chk("t6_accept", 32'(pressPulse), 32'b0100);
    tq.push_back(0);
    np = 0;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (last_tick) np++;
      if (pressPulse[2]) tq.push_back(np);
      if (np == 28 && buttonIn[2]) buttonIn[2] = 1'b0;
      if (releasePulse[2]) begin got = 1'b1; break; end
    end
    chk("t6_release_seen", 32'(got), 32'd1);
    chk("t6_pulse_count", 32'(tq.size()), 32'd7);
    for (int j = 1; j < tq.size() && j < 7; j++)
      chk($sformatf("t6_tick_%0d", j), 32'(tq[j]), 32'(4 + 4 * j));
    nr = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (pressPulse[2]) nr++;
    end
    chk("t6_none_after_release", 32'(nr), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
